// File: rtl/mod_counter_ctrl.sv
// Modulo-N counter with clear, clamped load, wrap/one-shot modes and cascade carry.
// Optional down-counting (up_i port) is built only when MOD_COUNTER_DOWN_EN is defined.
module mod_counter_ctrl #(
   parameter int unsigned WIDTH   = 3,
   parameter int unsigned MODULUS = 6
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
`ifdef MOD_COUNTER_DOWN_EN
   input  logic             up_i,
`endif
   input  logic             mode_i,
   input  logic             start_i,
   output logic [WIDTH-1:0] count_o,
   output logic             carry_out_o,
   output logic             done_o,
   output logic             busy_o
);

   localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;

   logic [WIDTH-1:0] term_val;
   logic [WIDTH-1:0] init_val;
   logic [WIDTH-1:0] step_val;
   logic [WIDTH-1:0] load_clamped;
   logic             at_term;

   // Terminal/initial values and the next step, re-evaluated from the current direction.
`ifdef MOD_COUNTER_DOWN_EN
   always_comb begin
      term_val = up_i ? CNT_MAX : '0;
      init_val = up_i ? '0 : CNT_MAX;
      if (count_q == term_val) begin
         step_val = init_val;
      end else if (up_i) begin
         step_val = count_q + WIDTH'(1);
      end else begin
         step_val = count_q - WIDTH'(1);
      end
   end
`else
   always_comb begin
      term_val = CNT_MAX;
      init_val = '0;
      if (count_q == CNT_MAX) begin
         step_val = '0;
      end else begin
         step_val = count_q + WIDTH'(1);
      end
   end
`endif

   assign at_term      = (count_q == term_val);
   assign load_clamped = ({1'b0, load_val_i} >= MOD_EXT) ? CNT_MAX : load_val_i;

   // Wrap only happens in free-running mode when no clear/load overrides the step.
   assign carry_out_o = en_i & ~mode_i & at_term & ~clr_i & ~load_i;

   always_comb begin
      state_d = state_q;
      count_d = count_q;

      if (clr_i) begin
         count_d = '0;
         state_d = ST_IDLE;
      end else if (load_i) begin
         count_d = load_clamped;
         if (!mode_i) begin
            state_d = ST_IDLE;
         end
      end else if (!mode_i) begin
         state_d = ST_IDLE;
         if (en_i) begin
            count_d = step_val;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  count_d = init_val;
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               if (start_i) begin
                  count_d = init_val;
               end else if (en_i) begin
                  // Never wrap in one-shot: a run already sitting on T just finishes.
                  if (at_term) begin
                     state_d = ST_DONE;
                  end else begin
                     count_d = step_val;
                     if (step_val == term_val) begin
                        state_d = ST_DONE;
                     end
                  end
               end
            end
            ST_DONE: begin
               if (start_i) begin
                  count_d = init_val;
                  state_d = ST_RUN;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      done_d = (state_d == ST_DONE);
      busy_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign count_o = count_q;
   assign done_o  = done_q;
   assign busy_o  = busy_q;

endmodule

// File: tb/tb_mod_counter_ctrl.sv
// Directed bench for mod_counter_ctrl (WIDTH=3, MODULUS=6) with hand-computed expectations.
// Down-count vectors run only when MOD_COUNTER_DOWN_EN is defined.
module tb_mod_counter_ctrl;

   localparam int unsigned WIDTH   = 3;
   localparam int unsigned MODULUS = 6;

   logic             clk_i = 1'b0;
   logic             reset_i;
   logic             en_i;
   logic             clr_i;
   logic             load_i;
   logic [WIDTH-1:0] load_val_i;
`ifdef MOD_COUNTER_DOWN_EN
   logic             up_i;
`endif
   logic             mode_i;
   logic             start_i;
   logic [WIDTH-1:0] count_o;
   logic             carry_out_o;
   logic             done_o;
   logic             busy_o;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   mod_counter_ctrl #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .en_i        (en_i),
      .clr_i       (clr_i),
      .load_i      (load_i),
      .load_val_i  (load_val_i),
`ifdef MOD_COUNTER_DOWN_EN
      .up_i        (up_i),
`endif
      .mode_i      (mode_i),
      .start_i     (start_i),
      .count_o     (count_o),
      .carry_out_o (carry_out_o),
      .done_o      (done_o),
      .busy_o      (busy_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_state(input string tag, input int c, input int b, input int d);
      chk({tag, ".count"}, 32'(count_o), 32'(c));
      chk({tag, ".busy"},  32'(busy_o),  32'(b));
      chk({tag, ".done"},  32'(done_o),  32'(d));
   endtask

   int exp_wrap [8] = '{1, 2, 3, 4, 5, 0, 1, 2};

   initial begin
      reset_i    = 1'b1;
      en_i       = 1'b0;
      clr_i      = 1'b0;
      load_i     = 1'b0;
      load_val_i = '0;
`ifdef MOD_COUNTER_DOWN_EN
      up_i       = 1'b1;
`endif
      mode_i     = 1'b0;
      start_i    = 1'b0;

      #1;
      chk_state("reset", 0, 0, 0);
      tick;
      reset_i = 1'b0;

      // Wrap mode: 8 enabled cycles from reset.
      en_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("wrap_carry%0d", i), 32'(carry_out_o), (i == 5) ? 32'd1 : 32'd0);
         tick;
         chk($sformatf("wrap_count%0d", i), 32'(count_o), 32'(exp_wrap[i]));
      end
      en_i = 1'b0;

      // Load clamp, then load beating a step.
      load_i = 1'b1; load_val_i = 3'd7;
      tick;
      chk("load_clamp", 32'(count_o), 32'd5);
      en_i = 1'b1; load_val_i = 3'd3;
      chk("carry_masked_by_load", 32'(carry_out_o), 32'd0);
      tick;
      chk("load_beats_step", 32'(count_o), 32'd3);
      load_i = 1'b0;
      tick;
      chk("step_after_load", 32'(count_o), 32'd4);

      // One-shot run up to T.
      mode_i = 1'b1; start_i = 1'b1;
      tick;
      chk_state("os_start", 0, 1, 0);
      start_i = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         tick;
         chk_state($sformatf("os_run%0d", k), k, (k < 5) ? 1 : 0, (k == 5) ? 1 : 0);
      end
      chk("os_no_carry", 32'(carry_out_o), 32'd0);
      tick;
      chk_state("os_hold", 5, 0, 1);
      start_i = 1'b1;
      tick;
      chk_state("os_restart_no_step", 0, 1, 0);
      start_i = 1'b0;
      tick;
      tick;
      chk_state("os_mid", 2, 1, 0);

      // Async reset between edges.
      #2;
      reset_i = 1'b1;
      #1;
      chk_state("async_reset", 0, 0, 0);
      reset_i = 1'b0;
      tick;
      chk_state("idle_after_reset", 0, 0, 0);

      // Mode 1->0 mid-run resumes wrap counting from current count.
      start_i = 1'b1;
      tick;
      start_i = 1'b0;
      tick;
      chk_state("pre_mode_switch", 1, 1, 0);
      mode_i = 1'b0;
      tick;
      chk_state("mode_to_wrap", 2, 0, 0);

      // clr + load + en in the same cycle during a run.
      mode_i = 1'b1; start_i = 1'b1;
      tick;
      start_i = 1'b0;
      tick;
      chk_state("pre_clr", 1, 1, 0);
      clr_i = 1'b1; load_i = 1'b1; load_val_i = 3'd4;
      tick;
      chk_state("clr_wins", 0, 0, 0);
      clr_i = 1'b0; load_i = 1'b0;
      tick;
      chk_state("idle_holds", 0, 0, 0);

`ifdef MOD_COUNTER_DOWN_EN
      // Down count, wrap then one-shot.
      up_i = 1'b0; mode_i = 1'b0;
      chk("down_carry0", 32'(carry_out_o), 32'd1);
      tick;
      chk("down_wrap", 32'(count_o), 32'd5);
      chk("down_carry5", 32'(carry_out_o), 32'd0);
      tick;
      chk("down_step", 32'(count_o), 32'd4);
      mode_i = 1'b1; start_i = 1'b1;
      tick;
      chk_state("down_os_start", 5, 1, 0);
      start_i = 1'b0;
      for (int k = 4; k >= 0; k--) begin
         tick;
         chk_state($sformatf("down_os%0d", k), k, (k > 0) ? 1 : 0, (k == 0) ? 1 : 0);
      end
      en_i = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mod_counter_ctrl.md
# mod_counter_ctrl

Parametrised modulo-N counter for the display/timing datapath. Counts 0..MODULUS-1 under enable, with synchronous clear, parallel load, optional down-counting, a combinational carry for cascading digits, and a one-shot mode that runs once to terminal count and then stops. It replaces fixed free-running modulo counters wherever a digit chain, timeout or sequence step needs start/stop control.

## Interface
- WIDTH, 3: count register width; MODULUS ≤ 2**WIDTH required.
- MODULUS, 6: count modulus; legal range 2..2**WIDTH.

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; one clock, no other reset
- en  in  1  count enable (one step per cycle while high)
- clr  in  1  synchronous clear
- load  in  1  synchronous parallel load strobe
- load_val  in  WIDTH  value loaded on load
- up  in  1  direction, 1 = up, 0 = down (present only with MOD_COUNTER_DOWN_EN)
- mode  in  1  0 = wrap (free-running), 1 = one-shot
- start  in  1  arms/restarts a one-shot run
- count  out  WIDTH  current count, registered
- carry_out  out  1  combinational: wrap occurs at this clock edge
- done  out  1  registered: one-shot run finished
- busy  out  1  registered: one-shot run in progress

## Operation
- Terminal value T: MODULUS-1 counting up, 0 counting down. Initial value I: 0 up, MODULUS-1 down.
- Priority each edge: reset > clr > load > start > count step.
- clr: count ← 0, FSM → IDLE, done ← 0.
- load: count ← load_val; if load_val ≥ MODULUS, count ← MODULUS-1 (clamp). FSM state unchanged.
- Wrap mode (mode=0): FSM held in IDLE, done=busy=0. With en: count==T → count ← I, else count ± 1. start ignored.
- One-shot mode (mode=1), FSM states IDLE, RUN, DONE:
  - IDLE: count held. start → count ← I, RUN.
  - RUN: busy=1. With en: count ± 1; if the new value is T → DONE. No wrap ever occurs in one-shot.
  - DONE: done=1, count held at T, en ignored. start → count ← I, RUN, done ← 0.
  - start in RUN: restart (count ← I, stay RUN).
- start and en in the same cycle: start wins, no step that cycle.
- mode change 1→0 mid-run: FSM → IDLE next edge, done/busy clear, wrap counting resumes from current count. 0→1: stays IDLE until start.
- carry_out = en & (mode==0) & (count==T) & ~clr & ~load. Always 0 in one-shot mode. Chain digits by driving next stage en from carry_out.
- Direction change mid-count takes effect the same edge; T/I re-evaluated from current up.
- Arithmetic modulo MODULUS only; count never exceeds MODULUS-1 except never (load clamps).

## Timing
- Reset (asynchronous assert): count=0, FSM=IDLE, done=0, busy=0, immediately; carry_out follows count/en combinationally.
- Count latency: one clock from en/load/clr/start to new count.
- done asserts on the same edge count reaches T in RUN; busy deasserts on that edge.
- carry_out valid in the cycle before the wrap edge; no registered delay.
- Reset deassertion mid-run: counter restarts from IDLE, count 0.

## Configuration
- MOD_COUNTER_DOWN_EN defined: up port present; up/down counting as above.
- Not defined: up port absent; direction fixed up (T=MODULUS-1, I=0); all down-count logic removed.

## Test plan
- Wrap mode, WIDTH=3, MODULUS=6, en=1 for 8 cycles from reset → count 1,2,3,4,5,0,1,2; carry_out high only while count=5.
- Load load_val=7 (≥ MODULUS) → count=5 next cycle; load_val=3 with en=1 → count=3 (load beats step), then 4.
- One-shot: mode=1, start pulse, en=1 → busy=1, count 0..5, done=1 and busy=0 on edge count=5; further en holds 5; second start → count=0, done=0, RUN.
- Down count (macro defined): up=0, wrap mode, from count=0 with en → 5 with carry_out=1 at count=0; one-shot down from start ends at 0 with done=1.
- Simultaneous events: clr+load+en same cycle → count=0, FSM IDLE; start+en in DONE → count=0, no step.
- Async reset asserted mid-run between clock edges → count=0, done=0, busy=0 without waiting for clk.
